// File: rtl/smg_pkg.sv
// Shared constants for the multiplexed 7-segment scan controller.
// Contents: register word offsets, CTRL field positions, and the hex glyph table.
// Glyphs are in logical polarity, laid out {g,f,e,d,c,b,a}, where 1 means lit.
package smg_pkg;

  localparam logic [2:0] REG_DIG0   = 3'd0;
  localparam logic [2:0] REG_DIG1   = 3'd1;
  localparam logic [2:0] REG_DIG2   = 3'd2;
  localparam logic [2:0] REG_DIG3   = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;
  localparam logic [2:0] REG_DECODE = 3'd5;

  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_B_LSB  = 4;

  // Entry n is the glyph for nibble n. Entry 15 is written first in the concatenation.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/smg_hex_decode.sv
// Purpose: combinational nibble to 7-segment glyph lookup, in logical polarity.
// Latency: 0 cycles. There is no backpressure (pure combinational logic).
// Ports: nib (4-bit hex value in), glyph ({g,f,e,d,c,b,a} out, 1 means lit).
module smg_hex_decode
  import smg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] glyph
);

  assign glyph = HEX_GLYPH[nib];

endmodule

// File: rtl/smg_scan_mm.sv
// Purpose: Avalon-MM slave that holds NUM_DIG digit bytes and time-multiplexes them onto shared segment pins.
// Latency: readdata is valid 1 cycle after the read strobe; pins follow the scan counters 1 cycle later.
// Backpressure: none. The slave has fixed latency with no waitrequest.
// Ports: csi_clk, csi_reset_n (async, active-low); avs_* 32-bit slave;
//        coe_dsel_dig (digit selects, bit k = digit k); coe_led_num_dig (segments {dp,g,f,e,d,c,b,a}).
module smg_scan_mm
  import smg_pkg::*;
#(
  parameter int NUM_DIG     = 6,
  parameter int SCAN_DIV    = 50000,
  parameter int BLANK_CYC   = 500,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit SEL_ACT_LOW = 1'b1
) (
  input  logic               csi_clk,
  input  logic               csi_reset_n,
  input  logic               avs_chipselect_n,
  input  logic [2:0]         avs_address,
  input  logic [3:0]         avs_byteenable_n,
  input  logic               avs_write_n,
  input  logic [31:0]        avs_writedata,
  input  logic               avs_read_n,
  output logic [31:0]        avs_readdata,
  output logic [NUM_DIG-1:0] coe_dsel_dig,
  output logic [7:0]         coe_led_num_dig
);

  localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // XOR masks: an inactive pin equals the mask, and an active pattern is logical ^ mask.
  localparam logic [NUM_DIG-1:0] SEL_OFF = {NUM_DIG{SEL_ACT_LOW}};
  localparam logic [7:0]         SEG_OFF = {8{SEG_ACT_LOW}};

  logic [7:0]         dig_q [NUM_DIG];
  logic               en_q;
  logic [3:0]         bri_q;
  logic [NUM_DIG-1:0] dec_q;

  logic [CNT_W-1:0]   slot_cnt;
  logic [IDX_W-1:0]   idx;
  logic [3:0]         frame;

  logic [7:0]         pat_q;
  logic [3:0]         bri_lat;

  logic               wr_en;
  logic               rd_en;
  logic [31:0]        rd_word;
  logic               slot_start;
  logic               slot_end;
  logic               idx_end;
  logic [7:0]         raw;
  logic [6:0]         glyph;
  logic [7:0]         live_pat;
  logic [7:0]         cur_pat;
  logic [3:0]         cur_bri;
  logic               digit_on;

  assign wr_en = !avs_chipselect_n && !avs_write_n;
  assign rd_en = !avs_chipselect_n && !avs_read_n;

  // Register file: each byte lane is gated by its own active-low enable.
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      for (int k = 0; k < NUM_DIG; k++) dig_q[k] <= '0;
      en_q  <= 1'b1;
      bri_q <= 4'hF;
      dec_q <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NUM_DIG; k++)
        if (avs_address == 3'(k / 4) && !avs_byteenable_n[k % 4])
          dig_q[k] <= avs_writedata[(k % 4) * 8 +: 8];
      if (avs_address == REG_CTRL && !avs_byteenable_n[0]) begin
        en_q  <= avs_writedata[CTRL_EN_BIT];
        bri_q <= avs_writedata[CTRL_B_LSB +: 4];
      end
      if (avs_address == REG_DECODE)
        for (int k = 0; k < NUM_DIG; k++)
          if (!avs_byteenable_n[k / 8]) dec_q[k] <= avs_writedata[k];
    end
  end

  always_comb begin
    rd_word = '0;
    case (avs_address)
      REG_DIG0, REG_DIG1, REG_DIG2, REG_DIG3: begin
        for (int k = 0; k < NUM_DIG; k++)
          if (avs_address == 3'(k / 4)) rd_word[(k % 4) * 8 +: 8] = dig_q[k];
      end
      REG_CTRL: begin
        rd_word[CTRL_EN_BIT]     = en_q;
        rd_word[CTRL_B_LSB +: 4] = bri_q;
      end
      REG_DECODE: rd_word[NUM_DIG-1:0] = dec_q;
      default: rd_word = '0;
    endcase
  end

  // The read mux samples the registers before this edge's write lands, so a read issued together with a write returns the old contents.
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n)   avs_readdata <= '0;
    else if (rd_en)     avs_readdata <= rd_word;
  end

  assign slot_start = (slot_cnt == '0);
  assign slot_end   = (slot_cnt == CNT_W'(SCAN_DIV - 1));
  assign idx_end    = (idx == IDX_W'(NUM_DIG - 1));

  // While disabled, the counters are parked at zero, so re-enabling starts again at digit 0.
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n || !en_q) begin
      slot_cnt <= '0;
      idx      <= '0;
      frame    <= '0;
    end else if (slot_end) begin
      slot_cnt <= '0;
      if (idx_end) begin
        idx   <= '0;
        frame <= frame + 4'd1;
      end else begin
        idx <= idx + 1'b1;
      end
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  assign raw = dig_q[idx];

  smg_hex_decode u_hex_decode (
    .nib   (raw[3:0]),
    .glyph (glyph)
  );

  assign live_pat = dec_q[idx] ? {raw[7], glyph} : raw;

  // Slot-start snapshot: the decoded pattern (so the decode choice is captured too) and the brightness.
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      pat_q   <= '0;
      bri_lat <= 4'hF;
    end else if (slot_start) begin
      pat_q   <= live_pat;
      bri_lat <= bri_q;
    end
  end

  // During the slot_cnt==0 cycle itself, the snapshot is still being captured, so use the live values.
  // This only matters when BLANK_CYC is 0.
  assign cur_pat  = slot_start ? live_pat : pat_q;
  assign cur_bri  = slot_start ? bri_q    : bri_lat;
  assign digit_on = en_q && (slot_cnt >= CNT_W'(BLANK_CYC)) && (frame <= cur_bri);

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      coe_dsel_dig    <= SEL_OFF;
      coe_led_num_dig <= SEG_OFF;
    end else if (digit_on) begin
      coe_dsel_dig    <= (NUM_DIG'(1) << idx) ^ SEL_OFF;
      coe_led_num_dig <= cur_pat ^ SEG_OFF;
    end else begin
      coe_dsel_dig    <= SEL_OFF;
      coe_led_num_dig <= SEG_OFF;
    end
  end

endmodule

// File: tb/tb_smg_scan_mm.sv
module tb_smg_scan_mm;

  localparam int ND = 6;
  localparam int SD = 16;
  localparam int BL = 2;

  logic        csi_clk = 1'b0;
  logic        csi_reset_n;
  logic        avs_chipselect_n;
  logic [2:0]  avs_address;
  logic [3:0]  avs_byteenable_n;
  logic        avs_write_n;
  logic [31:0] avs_writedata;
  logic        avs_read_n;
  logic [31:0] avs_readdata;
  logic [5:0]  coe_dsel_dig;
  logic [7:0]  coe_led_num_dig;

  int checks = 0;
  int errors = 0;

  // Behavioural view of the programmed state.
  logic [7:0] m_dig [ND];
  logic [5:0] m_dec;
  logic       m_en;
  logic [3:0] m_b;

  // Standard hex glyphs, {g,f,e,d,c,b,a}.
  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ben;
    logic [2:0]  ra;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [14];

  smg_scan_mm #(
    .NUM_DIG     (ND),
    .SCAN_DIV    (SD),
    .BLANK_CYC   (BL),
    .SEG_ACT_LOW (1'b1),
    .SEL_ACT_LOW (1'b1)
  ) dut (
    .csi_clk          (csi_clk),
    .csi_reset_n      (csi_reset_n),
    .avs_chipselect_n (avs_chipselect_n),
    .avs_address      (avs_address),
    .avs_byteenable_n (avs_byteenable_n),
    .avs_write_n      (avs_write_n),
    .avs_writedata    (avs_writedata),
    .avs_read_n       (avs_read_n),
    .avs_readdata     (avs_readdata),
    .coe_dsel_dig     (coe_dsel_dig),
    .coe_led_num_dig  (coe_led_num_dig)
  );

  always #5 csi_clk = ~csi_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic rst_shadow();
    for (int k = 0; k < ND; k++) m_dig[k] = 8'h00;
    m_dec = '0;
    m_en  = 1'b1;
    m_b   = 4'hF;
  endtask

  task automatic upd_shadow(input logic [2:0] a, input logic [31:0] d, input logic [3:0] ben);
    for (int j = 0; j < 4; j++) begin
      if (!ben[j]) begin
        if (a <= 3'd3) begin
          int k;
          k = 4 * int'(a) + j;
          if (k < ND) m_dig[k] = d[8*j +: 8];
        end else if (a == 3'd4 && j == 0) begin
          m_en = d[0];
          m_b  = d[7:4];
        end else if (a == 3'd5 && j == 0) begin
          m_dec = d[5:0];
        end
      end
    end
  endtask

  // Every bus task is entered and left 1 time unit after a rising edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] ben);
    avs_chipselect_n = 1'b0; avs_write_n = 1'b0;
    avs_address = a; avs_writedata = d; avs_byteenable_n = ben;
    @(posedge csi_clk); #1;
    avs_chipselect_n = 1'b1; avs_write_n = 1'b1; avs_byteenable_n = 4'hF;
  endtask

  task automatic wr_shadow(input logic [2:0] a, input logic [31:0] d, input logic [3:0] ben);
    bus_write(a, d, ben);
    upd_shadow(a, d, ben);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    avs_chipselect_n = 1'b0; avs_read_n = 1'b0; avs_address = a;
    @(posedge csi_clk); #1;
    avs_chipselect_n = 1'b1; avs_read_n = 1'b1;
    d = avs_readdata;
  endtask

  task automatic bus_rw(input logic [2:0] a, input logic [31:0] wd, input logic [3:0] ben,
                        output logic [31:0] rd);
    avs_chipselect_n = 1'b0; avs_read_n = 1'b0; avs_write_n = 1'b0;
    avs_address = a; avs_writedata = wd; avs_byteenable_n = ben;
    @(posedge csi_clk); #1;
    avs_chipselect_n = 1'b1; avs_read_n = 1'b1; avs_write_n = 1'b1; avs_byteenable_n = 4'hF;
    upd_shadow(a, wd, ben);
    rd = avs_readdata;
  endtask

  function automatic logic [7:0] pat(input int k);
    if (m_dec[k]) return {m_dig[k][7], glyph_tab[m_dig[k][3:0]]};
    return m_dig[k];
  endfunction

  // t = clocks elapsed since scanning started at slot 0 of digit 0 in frame 0.
  // The pins show the state at t one clock later.
  task automatic cmp_pins(input int t);
    int sc, slot, ix, fr;
    logic [5:0] es;
    logic [7:0] eg;
    sc   = t % SD;
    slot = t / SD;
    ix   = slot % ND;
    fr   = (slot / ND) % 16;
    if (m_en && sc >= BL && fr <= int'(m_b)) begin
      es = ~(6'(1) << ix);
      eg = ~pat(ix);
    end else begin
      es = 6'h3F;
      eg = 8'hFF;
    end
    chk($sformatf("dsel t=%0d", t), 32'(coe_dsel_dig), 32'(es));
    chk($sformatf("seg t=%0d", t), 32'(coe_led_num_dig), 32'(eg));
  endtask

  // Edge e after the scan start shows the state at t = e-1.
  task automatic check_scan(input int e_first, input int e_last, output int lit);
    lit = 0;
    for (int e = e_first; e <= e_last; e++) begin
      @(posedge csi_clk); #1;
      cmp_pins(e - 1);
      if (coe_dsel_dig != 6'h3F) lit++;
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          lit;
    int          b;

    avs_chipselect_n = 1'b1; avs_write_n = 1'b1; avs_read_n = 1'b1;
    avs_address = '0; avs_writedata = '0; avs_byteenable_n = 4'hF;
    csi_reset_n = 1'b1;
    #1 csi_reset_n = 1'b0;
    repeat (3) @(posedge csi_clk);
    #1;
    rst_shadow();
    chk("reset dsel", 32'(coe_dsel_dig), 32'h3F);
    chk("reset seg", 32'(coe_led_num_dig), 32'hFF);
    chk("reset readdata", avs_readdata, 32'h0);
    csi_reset_n = 1'b1;
    bus_read(3'd4, rd);
    chk("reset CTRL read", rd, 32'h000000F1);

    // Register access table.
    vt[0]  = '{3'd0, 32'hAABBCCDD, 4'b1010, 3'd0, 32'h00BB00DD};
    vt[1]  = '{3'd1, 32'h11223344, 4'b0000, 3'd1, 32'h00003344};
    vt[2]  = '{3'd2, 32'hFFFFFFFF, 4'b0000, 3'd2, 32'h00000000};
    vt[3]  = '{3'd3, 32'h12345678, 4'b0000, 3'd3, 32'h00000000};
    vt[4]  = '{3'd4, 32'hFFFFFFFF, 4'b0000, 3'd4, 32'h000000F1};
    vt[5]  = '{3'd4, 32'h00000030, 4'b1110, 3'd4, 32'h00000030};
    vt[6]  = '{3'd5, 32'hFFFFFFFF, 4'b0000, 3'd5, 32'h0000003F};
    vt[7]  = '{3'd5, 32'h00000015, 4'b1110, 3'd5, 32'h00000015};
    vt[8]  = '{3'd5, 32'h000000FF, 4'b1111, 3'd5, 32'h00000015};
    vt[9]  = '{3'd6, 32'hFFFFFFFF, 4'b0000, 3'd0, 32'h00BB00DD};
    vt[10] = '{3'd6, 32'hFFFFFFFF, 4'b0000, 3'd4, 32'h00000030};
    vt[11] = '{3'd7, 32'h00000000, 4'b1111, 3'd7, 32'h00000000};
    vt[12] = '{3'd6, 32'hFFFFFFFF, 4'b0000, 3'd6, 32'h00000000};
    vt[13] = '{3'd0, 32'h00EE0000, 4'b1011, 3'd0, 32'h00EE00DD};
    for (int i = 0; i < 14; i++) begin
      wr_shadow(vt[i].wa, vt[i].wd, vt[i].ben);
      bus_read(vt[i].ra, rd);
      chk($sformatf("regvec %0d", i), rd, vt[i].exp);
    end

    // A read issued together with a write returns the old word; readdata then holds between reads.
    bus_rw(3'd1, 32'h00000099, 4'b1110, rd);
    chk("rw pre-write value", rd, 32'h00003344);
    bus_read(3'd1, rd);
    chk("rw post-write value", rd, 32'h00003399);
    repeat (3) @(posedge csi_clk);
    #1;
    chk("readdata hold", avs_readdata, 32'h00003399);

    // Raw scan.
    wr_shadow(3'd4, 32'h0, 4'h0);
    wr_shadow(3'd0, 32'h04030201, 4'h0);
    wr_shadow(3'd1, 32'h00000605, 4'h0);
    wr_shadow(3'd5, 32'h0, 4'h0);
    wr_shadow(3'd4, 32'hF1, 4'h0);
    check_scan(1, 2 * ND * SD + 8, lit);

    // Hex decode: digit 0 shows glyph A with dp.
    wr_shadow(3'd4, 32'h0, 4'h0);
    wr_shadow(3'd0, 32'h0000008A, 4'b1110);
    wr_shadow(3'd5, 32'h01, 4'h0);
    wr_shadow(3'd4, 32'hF1, 4'h0);
    check_scan(1, BL, lit);
    @(posedge csi_clk); #1;
    chk("decode A dsel", 32'(coe_dsel_dig), 32'h3E);
    chk("decode A seg", 32'(coe_led_num_dig), 32'(8'h08));
    check_scan(BL + 2, ND * SD + 4, lit);

    // Brightness: each lit frame has ND*(SD-BL) lit clocks.
    wr_shadow(3'd4, 32'h0, 4'h0);
    wr_shadow(3'd4, 32'h31, 4'h0);
    check_scan(1, 16 * ND * SD, lit);
    chk("B=3 lit clocks", 32'(lit), 32'(4 * ND * (SD - BL)));
    wr_shadow(3'd4, 32'h0, 4'h0);
    wr_shadow(3'd4, 32'h01, 4'h0);
    check_scan(1, 16 * ND * SD, lit);
    chk("B=0 lit clocks", 32'(lit), 32'(ND * (SD - BL)));

    // Randomized contents and brightness.
    for (int it = 0; it < 3; it++) begin
      wr_shadow(3'd4, 32'h0, 4'h0);
      wr_shadow(3'd0, $urandom, 4'h0);
      wr_shadow(3'd1, $urandom, 4'h0);
      wr_shadow(3'd5, $urandom, 4'h0);
      b = $urandom_range(0, 15);
      wr_shadow(3'd4, {24'h0, 4'(b), 4'b0001}, 4'h0);
      check_scan(1, 16 * ND * SD, lit);
      chk($sformatf("random B=%0d lit clocks", b), 32'(lit), 32'((b + 1) * ND * (SD - BL)));
    end

    // Enable cleared mid-slot, then re-enabled.
    wr_shadow(3'd4, 32'h0, 4'h0);
    wr_shadow(3'd5, 32'h0, 4'h0);
    wr_shadow(3'd0, 32'h04030201, 4'h0);
    wr_shadow(3'd4, 32'hF1, 4'h0);
    check_scan(1, 8, lit);
    bus_write(3'd4, 32'hF0, 4'h0);
    cmp_pins(8);
    upd_shadow(3'd4, 32'hF0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge csi_clk); #1;
      chk($sformatf("disabled dsel %0d", i), 32'(coe_dsel_dig), 32'h3F);
      chk($sformatf("disabled seg %0d", i), 32'(coe_led_num_dig), 32'hFF);
    end
    wr_shadow(3'd4, 32'hF1, 4'h0);
    check_scan(1, ND * SD + 20, lit);

    // A mid-slot write must not tear the digit being shown.
    wr_shadow(3'd4, 32'h0, 4'h0);
    wr_shadow(3'd0, 32'h00000011, 4'h0);
    wr_shadow(3'd4, 32'hF1, 4'h0);
    check_scan(1, 5, lit);
    bus_write(3'd0, 32'h00000022, 4'b1110);
    cmp_pins(5);
    check_scan(7, SD, lit);
    upd_shadow(3'd0, 32'h00000022, 4'b1110);
    check_scan(SD + 1, ND * SD + 2 * SD, lit);

    // Reset mid-scan.
    check_scan(ND * SD + 2 * SD + 1, ND * SD + 2 * SD + 3, lit);
    csi_reset_n = 1'b0;
    #1;
    chk("midscan reset dsel", 32'(coe_dsel_dig), 32'h3F);
    chk("midscan reset seg", 32'(coe_led_num_dig), 32'hFF);
    chk("midscan reset readdata", avs_readdata, 32'h0);
    @(posedge csi_clk); #1;
    csi_reset_n = 1'b1;
    rst_shadow();
    check_scan(1, ND * SD + 10, lit);
    bus_read(3'd0, rd);
    chk("after reset DIG0", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
